// File: rtl/zx_sram_arbiter_pkg.sv
// Shared types for the video/CPU SRAM arbiter: arbitration mode and sequencer states.
package zx_sram_arbiter_pkg;

    typedef enum logic {
        ARB_FIXED,
        ARB_RR
    } arb_mode_t;

    typedef enum logic [2:0] {
        SRAM_IDLE,
        SRAM_RD,
        SRAM_WR_SETUP,
        SRAM_WR,
        SRAM_WR_RECOVER
    } sram_state_t;

endpackage

// File: rtl/zx_arb_pick.sv
// Combinational priority picker: channel 0 absolute, channels 1..NCH-1 fixed or round-robin.
module zx_arb_pick
    import zx_sram_arbiter_pkg::*;
#(
    parameter int NCH = 4,
    parameter int PW  = 2
) (
    input  logic [NCH-1:0] i_req,
    input  logic [PW-1:0]  i_ptr,
    input  arb_mode_t      i_mode,
    output logic [NCH-1:0] o_gnt,
    output logic           o_valid
);

    logic [NCH-1:0] w_ge;
    logic [NCH-1:0] w_hi;
    logic [NCH-1:0] w_any;

    // Lowest set index among 1..NCH-1, as a one-hot vector.
    function automatic logic [NCH-1:0] first_set(input logic [NCH-1:0] v);
        logic [NCH-1:0] r;
        logic           f;
        r = '0;
        f = 1'b0;
        for (int i = 1; i < NCH; i++) begin
            if (v[i] && !f) begin
                r[i] = 1'b1;
                f    = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        w_ge = '0;
        for (int i = 1; i < NCH; i++) begin
            w_ge[i] = (i >= int'(i_ptr));
        end
        w_hi    = first_set(i_req & w_ge);
        w_any   = first_set(i_req);
        o_valid = |i_req;
        o_gnt   = '0;
        // Round-robin: first request at/after the pointer, otherwise wrap to the lowest one.
        if (i_req[0]) begin
            o_gnt[0] = 1'b1;
        end else if (i_mode == ARB_RR && |w_hi) begin
            o_gnt = w_hi;
        end else begin
            o_gnt = w_any;
        end
    end

endmodule

// File: rtl/zx_sram_arbiter.sv
// Shared 512K video/CPU SRAM arbiter and strobe sequencer with write setup/recovery.
module zx_sram_arbiter
    import zx_sram_arbiter_pkg::*;
#(
    parameter int        NCH        = 4,
    parameter int        AW         = 19,
    parameter int        DW         = 8,
    parameter int        ACC_CYCLES = 2,
    parameter arb_mode_t ARB_MODE   = ARB_RR
) (
    input  logic              clk28,
    input  logic              rst_n,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    we,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    output logic [NCH-1:0]    gnt,
    output logic [NCH-1:0]    ack,
    output logic [DW-1:0]     rdata,
    output logic              busy,
    output logic [AW-1:0]     va,
    input  logic [DW-1:0]     vd_in,
    output logic [DW-1:0]     vd_out,
    output logic              vd_oe,
    output logic              n_vrd,
    output logic              n_vwr
);

    localparam int             PW      = (NCH > 2) ? $clog2(NCH) : 1;
    localparam logic [2:0]     RD_LAST = 3'(ACC_CYCLES - 1);
    localparam logic [2:0]     WR_LAST = 3'(ACC_CYCLES - 2);
    localparam logic [NCH-1:0] ONE     = NCH'(1);

    sram_state_t      r_state;
    logic [2:0]       r_cnt;
    logic [PW-1:0]    r_ch;
    logic [PW-1:0]    r_ptr;
    logic [NCH-1:0]   r_gnt;
    logic [NCH-1:0]   r_ack;
    logic [DW-1:0]    r_rdata;
    logic             r_busy;
    logic [AW-1:0]    r_va;
    logic [DW-1:0]    r_vd_out;
    logic             r_vd_oe;
    logic             r_n_vrd;
    logic             r_n_vwr;

    logic [NCH-1:0]   w_mreq;
    logic [NCH-1:0]   w_sel;
    logic             w_valid;
    logic [PW-1:0]    w_idx;
    logic [PW-1:0]    w_nptr;
    logic [AW-1:0]    w_addr;
    logic [DW-1:0]    w_wdata;
    logic             w_we;
    logic [NCH-1:0]   w_ack_oh;

    // The channel being acked this cycle must not win again off its stale req.
    assign w_mreq   = req & ~r_ack;
    assign w_ack_oh = ONE << r_ch;
    assign w_nptr   = (w_idx == PW'(NCH - 1)) ? PW'(1) : w_idx + PW'(1);

    zx_arb_pick #(
        .NCH (NCH),
        .PW  (PW)
    ) u_pick (
        .i_req   (w_mreq),
        .i_ptr   (r_ptr),
        .i_mode  (ARB_MODE),
        .o_gnt   (w_sel),
        .o_valid (w_valid)
    );

    always_comb begin
        w_idx   = '0;
        w_addr  = '0;
        w_wdata = '0;
        w_we    = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (w_sel[i]) begin
                w_idx   = PW'(i);
                w_addr  = addr[i*AW +: AW];
                w_wdata = wdata[i*DW +: DW];
                w_we    = we[i];
            end
        end
    end

    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            r_state  <= SRAM_IDLE;
            r_cnt    <= '0;
            r_ch     <= '0;
            r_ptr    <= PW'(1);
            r_gnt    <= '0;
            r_ack    <= '0;
            r_rdata  <= '0;
            r_busy   <= 1'b0;
            r_va     <= '0;
            r_vd_out <= '0;
            r_vd_oe  <= 1'b0;
            r_n_vrd  <= 1'b1;
            r_n_vwr  <= 1'b1;
        end else begin
            r_gnt <= '0;
            r_ack <= '0;
            case (r_state)
                SRAM_IDLE: begin
                    if (w_valid) begin
                        r_gnt    <= w_sel;
                        r_ch     <= w_idx;
                        r_va     <= w_addr;
                        r_vd_out <= w_wdata;
                        r_busy   <= 1'b1;
                        if (!w_sel[0]) r_ptr <= w_nptr;
                        if (w_we) begin
                            r_state <= SRAM_WR_SETUP;
                            r_vd_oe <= 1'b1;
                        end else begin
                            r_state <= SRAM_RD;
                            r_n_vrd <= 1'b0;
                            r_cnt   <= RD_LAST;
                        end
                    end
                end
                SRAM_RD: begin
                    if (r_cnt == 3'd0) begin
                        r_rdata <= vd_in;
                        r_n_vrd <= 1'b1;
                        r_ack   <= w_ack_oh;
                        r_busy  <= 1'b0;
                        r_state <= SRAM_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                SRAM_WR_SETUP: begin
                    r_n_vwr <= 1'b0;
                    r_cnt   <= WR_LAST;
                    r_state <= SRAM_WR;
                end
                SRAM_WR: begin
                    if (r_cnt == 3'd0) begin
                        r_n_vwr <= 1'b1;
                        r_state <= SRAM_WR_RECOVER;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                SRAM_WR_RECOVER: begin
                    r_vd_oe <= 1'b0;
                    r_ack   <= w_ack_oh;
                    r_busy  <= 1'b0;
                    r_state <= SRAM_IDLE;
                end
                default: r_state <= SRAM_IDLE;
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign ack    = r_ack;
    assign rdata  = r_rdata;
    assign busy   = r_busy;
    assign va     = r_va;
    assign vd_out = r_vd_out;
    assign vd_oe  = r_vd_oe;
    assign n_vrd  = r_n_vrd;
    assign n_vwr  = r_n_vwr;

endmodule

// File: tb/tb_zx_sram_arbiter.sv
// Scoreboard bench: instance A (NCH=4, ACC=2, fixed), instance B (NCH=8, ACC=7, round-robin).
module tb_zx_sram_arbiter;
    import zx_sram_arbiter_pkg::*;

    logic clk28 = 1'b0;
    always #5 clk28 = ~clk28;
    logic rst_n;

    logic [3:0]   reqa, wea, gnta, acka;
    logic [75:0]  addra;
    logic [31:0]  wdataa;
    logic [7:0]   rdataa, vdia, vdoa;
    logic [18:0]  vaa;
    logic         busya, oea, nrda, nwra;

    logic [7:0]   reqb, web, gntb, ackb;
    logic [151:0] addrb;
    logic [63:0]  wdatab;
    logic [7:0]   rdatab, vdib, vdob;
    logic [18:0]  vab;
    logic         busyb, oeb, nrdb, nwrb;

    logic [7:0] memA [0:524287];
    logic [7:0] memB [0:524287];

    zx_sram_arbiter #(.NCH(4), .AW(19), .DW(8), .ACC_CYCLES(2), .ARB_MODE(ARB_FIXED)) u_a (
        .clk28(clk28), .rst_n(rst_n), .req(reqa), .we(wea), .addr(addra), .wdata(wdataa),
        .gnt(gnta), .ack(acka), .rdata(rdataa), .busy(busya), .va(vaa), .vd_in(vdia),
        .vd_out(vdoa), .vd_oe(oea), .n_vrd(nrda), .n_vwr(nwra));

    zx_sram_arbiter #(.NCH(8), .AW(19), .DW(8), .ACC_CYCLES(7), .ARB_MODE(ARB_RR)) u_b (
        .clk28(clk28), .rst_n(rst_n), .req(reqb), .we(web), .addr(addrb), .wdata(wdatab),
        .gnt(gntb), .ack(ackb), .rdata(rdatab), .busy(busyb), .va(vab), .vd_in(vdib),
        .vd_out(vdob), .vd_oe(oeb), .n_vrd(nrdb), .n_vwr(nwrb));

    // SRAM models: asynchronous read, write latched while n_vwr is low.
    assign vdia = memA[vaa];
    assign vdib = memB[vab];
    always @(posedge clk28) begin
        if (!nwra && oea) memA[vaa] <= vdoa;
        if (!nwrb && oeb) memB[vab] <= vdob;
    end

    int cyc = 0;
    always @(posedge clk28) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct { int ch; int cyc; } gexp_t;
    typedef struct { int ch; bit rd; logic [7:0] data; int cyc; } aexp_t;
    gexp_t gqa[$], gqb[$];
    aexp_t aqa[$], aqb[$];

    logic [7:0] hold_b = 8'h00;
    int         hold_lim = 0;
    int         acks_b = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic mon(input int id, input logic [7:0] g, input logic [7:0] a, input logic [7:0] rd);
        gexp_t ge;
        aexp_t ae;
        int    gn, an;
        gn = (id == 0) ? gqa.size() : gqb.size();
        an = (id == 0) ? aqa.size() : aqb.size();
        if (g != 8'h00) begin
            if (gn == 0) chk("gnt_unexpected", 32'(g), 32'd0);
            else begin
                if (id == 0) ge = gqa.pop_front(); else ge = gqb.pop_front();
                chk("gnt_ch", 32'(g), 32'(1) << ge.ch);
                if (ge.cyc >= 0) chk("gnt_cycle", 32'(cyc), 32'(ge.cyc));
            end
        end
        if (a != 8'h00) begin
            if (an == 0) chk("ack_unexpected", 32'(a), 32'd0);
            else begin
                if (id == 0) ae = aqa.pop_front(); else ae = aqb.pop_front();
                chk("ack_ch", 32'(a), 32'(1) << ae.ch);
                if (ae.cyc >= 0) chk("ack_cycle", 32'(cyc), 32'(ae.cyc));
                if (ae.rd) chk("rdata", 32'(rd), 32'(ae.data));
            end
        end
    endtask

    always @(negedge clk28) begin
        mon(0, {4'b0, gnta}, {4'b0, acka}, rdataa);
        mon(1, gntb, ackb, rdatab);
        chk("a_rd_wr_overlap", 32'(!nrda && !nwra), 32'd0);
        chk("a_oe_during_rd",  32'(oea && !nrda),   32'd0);
        chk("b_rd_wr_overlap", 32'(!nrdb && !nwrb), 32'd0);
        chk("b_oe_during_rd",  32'(oeb && !nrdb),   32'd0);
        if (hold_b != 8'h00 && ackb != 8'h00) begin
            acks_b++;
            if (acks_b == hold_lim) begin
                reqb   = 8'h00;
                hold_b = 8'h00;
            end
        end
        reqa = reqa & ~acka;
        reqb = reqb & ~(ackb & ~hold_b);
    end

    task automatic drain(input int budget);
        int k = 0;
        while ((gqa.size() + aqa.size() + gqb.size() + aqb.size()) != 0 && k < budget) begin
            @(negedge clk28);
            k++;
        end
        chk("scoreboard_drain", 32'(gqa.size() + aqa.size() + gqb.size() + aqb.size()), 32'd0);
        @(negedge clk28);
    endtask

    task automatic rd_a(input int ch, input logic [18:0] ad, input logic [7:0] d);
        int c;
        memA[ad] = d;
        addra[ch*19 +: 19] = ad;
        wea[ch] = 1'b0;
        reqa[ch] = 1'b1;
        c = cyc;
        gqa.push_back('{ch, c + 1});
        aqa.push_back('{ch, 1'b1, d, c + 3});
        @(negedge clk28);
        chk("rd_va", 32'(vaa), 32'(ad));
        chk("rd_nvrd_t1", 32'(nrda), 32'd0);
        @(negedge clk28);
        chk("rd_nvrd_t2", 32'(nrda), 32'd0);
        @(negedge clk28);
        chk("rd_nvrd_ack", 32'(nrda), 32'd1);
    endtask

    task automatic wr_a(input int ch, input logic [18:0] ad, input logic [7:0] d);
        int c;
        addra[ch*19 +: 19] = ad;
        wdataa[ch*8 +: 8] = d;
        wea[ch] = 1'b1;
        reqa[ch] = 1'b1;
        c = cyc;
        gqa.push_back('{ch, c + 1});
        aqa.push_back('{ch, 1'b0, 8'h00, c + 4});
        @(negedge clk28);
        chk("wr_setup_oe", 32'(oea), 32'd1);
        chk("wr_setup_nvwr", 32'(nwra), 32'd1);
        chk("wr_setup_vdout", 32'(vdoa), 32'(d));
        chk("wr_setup_va", 32'(vaa), 32'(ad));
        @(negedge clk28);
        chk("wr_strobe_nvwr", 32'(nwra), 32'd0);
        chk("wr_strobe_oe", 32'(oea), 32'd1);
        @(negedge clk28);
        chk("wr_recover_nvwr", 32'(nwra), 32'd1);
        chk("wr_recover_oe", 32'(oea), 32'd1);
        @(negedge clk28);
        chk("wr_ack_oe", 32'(oea), 32'd0);
        chk("wr_sram_data", 32'(memA[ad]), 32'(d));
        wea[ch] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        int k;
        int order [7] = '{1, 2, 0, 3, 1, 2, 3};
        rst_n = 1'b0;
        reqa = '0; wea = '0; addra = '0; wdataa = '0;
        reqb = '0; web = '0; addrb = '0; wdatab = '0;
        repeat (3) @(negedge clk28);
        chk("rst_gnt", 32'(gnta), 32'd0);
        chk("rst_ack", 32'(acka), 32'd0);
        chk("rst_rdata", 32'(rdataa), 32'd0);
        chk("rst_busy", 32'(busya), 32'd0);
        chk("rst_va", 32'(vaa), 32'd0);
        chk("rst_vdout", 32'(vdoa), 32'd0);
        chk("rst_oe", 32'(oea), 32'd0);
        chk("rst_nvrd", 32'(nrda), 32'd1);
        chk("rst_nvwr", 32'(nwra), 32'd1);
        chk("rst_b_strobes", 32'({nrdb, nwrb, oeb, busyb}), 32'hC);
        rst_n = 1'b1;
        @(negedge clk28);

        rd_a(1, 19'h7A123, 8'h5C);
        drain(20);
        wr_a(2, 19'h00400, 8'hA5);
        drain(20);

        // Fixed priority: 0, then 2, then 3.
        memA[19'h11100] = 8'h30; memA[19'h22200] = 8'h32; memA[19'h33300] = 8'h33;
        addra[0 +: 19] = 19'h11100; addra[38 +: 19] = 19'h22200; addra[57 +: 19] = 19'h33300;
        c = cyc;
        gqa.push_back('{0, c + 1}); aqa.push_back('{0, 1'b1, 8'h30, c + 3});
        gqa.push_back('{2, c + 4}); aqa.push_back('{2, 1'b1, 8'h32, c + 6});
        gqa.push_back('{3, c + 7}); aqa.push_back('{3, 1'b1, 8'h33, c + 9});
        reqa = 4'b1101;
        drain(40);

        // Reset during the write strobe aborts the access without an ack.
        addra[19 +: 19] = 19'h01234; wdataa[8 +: 8] = 8'h99; wea[1] = 1'b1; reqa[1] = 1'b1;
        c = cyc;
        gqa.push_back('{1, c + 1});
        @(negedge clk28);
        chk("abort_setup_oe", 32'(oea), 32'd1);
        @(negedge clk28);
        chk("abort_in_wr", 32'(nwra), 32'd0);
        rst_n = 1'b0; reqa = '0; wea = '0;
        @(negedge clk28);
        chk("abort_nvwr", 32'(nwra), 32'd1);
        chk("abort_oe", 32'(oea), 32'd0);
        chk("abort_busy", 32'(busya), 32'd0);
        chk("abort_ack", 32'(acka), 32'd0);
        chk("abort_nvrd", 32'(nrda), 32'd1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk28);
        rd_a(3, 19'h05555, 8'h6E);
        drain(20);

        // Channel 7 read with 7-cycle strobe.
        memB[19'h7FFFF] = 8'hC7;
        addrb[7*19 +: 19] = 19'h7FFFF;
        reqb[7] = 1'b1;
        c = cyc;
        gqb.push_back('{7, c + 1});
        aqb.push_back('{7, 1'b1, 8'hC7, c + 8});
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk28);
            chk("b_nvrd_low", 32'(nrdb), 32'd0);
        end
        @(negedge clk28);
        chk("b_nvrd_ack", 32'(nrdb), 32'd1);
        drain(20);

        // Round-robin with channels 1..3 held; channel 0 cuts in once.
        for (int i = 0; i < 4; i++) begin
            memB[i*256] = 8'(8'h40 + i);
            addrb[i*19 +: 19] = 19'(i * 256);
        end
        for (int i = 0; i < 7; i++) begin
            gqb.push_back('{order[i], -1});
            aqb.push_back('{order[i], 1'b1, 8'(8'h40 + order[i]), -1});
        end
        acks_b = 0; hold_lim = 7; hold_b = 8'h0E;
        reqb[3:1] = 3'b111;
        k = 0;
        while (!gntb[2] && k < 100) begin
            @(negedge clk28);
            k++;
        end
        chk("rr_wait_ch2", 32'(gntb[2]), 32'd1);
        reqb[0] = 1'b1;
        drain(200);
        chk("rr_req_released", 32'(reqb), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
